// File: rtl/display_hex_varredura_pkg.sv
// Shared constants for the multiplexed hex display: segment patterns and width helpers.
// No logic, no latency.
// No backpressure; consumed by the decoder and the scan controller.
package display_hex_varredura_pkg;

  // Segment patterns, bit order [0:6] = a..g, active low (0 = lit)
  localparam logic [0:6] SEG_0       = 7'b0000001;
  localparam logic [0:6] SEG_1       = 7'b1001111;
  localparam logic [0:6] SEG_2       = 7'b0010010;
  localparam logic [0:6] SEG_3       = 7'b0000110;
  localparam logic [0:6] SEG_4       = 7'b1001100;
  localparam logic [0:6] SEG_5       = 7'b0100100;
  localparam logic [0:6] SEG_6       = 7'b0100000;
  localparam logic [0:6] SEG_7       = 7'b0001111;
  localparam logic [0:6] SEG_8       = 7'b0000000;
  localparam logic [0:6] SEG_9       = 7'b0000100;
  localparam logic [0:6] SEG_A       = 7'b0001000;
  localparam logic [0:6] SEG_B       = 7'b1100000;
  localparam logic [0:6] SEG_C       = 7'b0110001;
  localparam logic [0:6] SEG_D       = 7'b1000010;
  localparam logic [0:6] SEG_E       = 7'b0110000;
  localparam logic [0:6] SEG_F       = 7'b0111000;
  localparam logic [0:6] SEG_APAGADO = 7'b1111111;

  // Counter width able to hold 0..n-1; never collapses to zero bits
  function automatic int largura(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_hex_varredura_if.sv
// Load handshake between the datapath and the display controller.
// No logic, no latency.
// carga is honoured only while pronto=1; otherwise the strobe is dropped.
interface display_hex_varredura_if #(
  parameter int N_DIGITOS = 4
);
  logic                   carga;
  logic [4*N_DIGITOS-1:0] entrada;
  logic                   pronto;

  modport master (output carga, output entrada, input pronto);
  modport slave  (input carga, input entrada, output pronto);
endinterface

// File: rtl/display_hex_varredura_seg7.sv
// Hex digit to 7-segment pattern (a..g, active low).
// Purely combinational, zero latency.
// No backpressure.
module decodificador_seg7
  import display_hex_varredura_pkg::*;
(
  input  logic [3:0] digito,
  output logic [0:6] seg
);

  // Table lookup of the segment pattern for one nibble
  always_comb begin
    seg = SEG_APAGADO;
    case (digito)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/display_hex_varredura.sv
// Multiplexed N-digit hex 7-segment controller with tear-free loads, blink and zero suppression.
// Outputs registered one cycle after the scan index; loads appear at the next frame boundary.
// pronto stays low from an accepted load until its commit; carga while pronto=0 is ignored.
module display_hex_varredura
  import display_hex_varredura_pkg::*;
#(
  parameter int N_DIGITOS     = 4,
  parameter int DIV_VARREDURA = 50000,
  parameter int PERIODO_PISCA = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  display_hex_varredura_if.slave carga_if,
  input  logic                  supressao_zeros,
  input  logic [N_DIGITOS-1:0]  pisca,
  output logic [0:6]            saida,
  output logic [N_DIGITOS-1:0]  anodo
);

  localparam int LARG_CNT = largura(DIV_VARREDURA);
  localparam int LARG_IDX = largura(N_DIGITOS);
  localparam int LARG_QDR = largura(PERIODO_PISCA);
  localparam int LARG_VAL = 4 * N_DIGITOS;

  logic [LARG_CNT-1:0]  prescaler;
  logic [LARG_IDX-1:0]  idx;
  logic [LARG_QDR-1:0]  quadros;
  logic                 fase;
  logic [LARG_VAL-1:0]  sombra;
  logic [LARG_VAL-1:0]  exibido;
  logic                 pendente;

  logic                 tick;
  logic                 fim_quadro;
  logic [3:0]           digito;
  logic [N_DIGITOS-1:0] zeros_acima;
  logic                 apagado;
  logic [0:6]           seg;

  assign tick       = (prescaler == LARG_CNT'(DIV_VARREDURA - 1));
  assign fim_quadro = tick && (idx == LARG_IDX'(N_DIGITOS - 1));

  // A load is outstanding exactly while pendente is set, so pronto is its inverse
  assign carga_if.pronto = ~pendente;

  // Scan timing: prescaler sets dwell per digit, idx walks the digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (tick) begin
      prescaler <= '0;
      idx       <= (idx == LARG_IDX'(N_DIGITOS - 1)) ? '0 : idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Load handshake: capture into the shadow, publish only at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sombra   <= '0;
      exibido  <= '0;
      pendente <= 1'b0;
    end else if (fim_quadro && pendente) begin
      exibido  <= sombra;
      pendente <= 1'b0;
    end else if (carga_if.carga && !pendente) begin
      sombra   <= carga_if.entrada;
      pendente <= 1'b1;
    end
  end

  // Blink phase: flips every PERIODO_PISCA completed frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quadros <= '0;
      fase    <= 1'b0;
    end else if (fim_quadro) begin
      if (quadros == LARG_QDR'(PERIODO_PISCA - 1)) begin
        quadros <= '0;
        fase    <= ~fase;
      end else begin
        quadros <= quadros + 1'b1;
      end
    end
  end

  // Pick the nibble under scan and mark digits whose value and all higher digits are zero
  always_comb begin
    logic acumula;
    digito  = '0;
    acumula = 1'b1;
    zeros_acima = '0;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      acumula        = acumula && (exibido[4*i +: 4] == 4'h0);
      zeros_acima[i] = acumula;
      if (idx == LARG_IDX'(i)) digito = exibido[4*i +: 4];
    end
    // The units digit always shows, even for an all-zero value
    zeros_acima[0] = 1'b0;
    apagado = (pisca[idx] && fase) || (supressao_zeros && zeros_acima[idx]);
  end

  decodificador_seg7 u_seg7 (
    .digito (digito),
    .seg    (seg)
  );

  // Registered pin drivers: one anode low for the scanned digit, or all dark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida <= SEG_APAGADO;
      anodo <= '1;
    end else if (apagado) begin
      saida <= SEG_APAGADO;
      anodo <= '1;
    end else begin
      saida <= seg;
      anodo <= ~(N_DIGITOS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_display_hex_varredura.sv
// Self-checking bench: directed scenarios plus random loads against a frame-arithmetic model.
module tb_display_hex_varredura;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int P   = 2;
  localparam int F   = N * DIV;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           supressao_zeros;
  logic [N-1:0]   pisca;
  logic [0:6]     saida;
  logic [N-1:0]   anodo;

  display_hex_varredura_if #(.N_DIGITOS(N)) bus ();

  display_hex_varredura #(
    .N_DIGITOS     (N),
    .DIV_VARREDURA (DIV),
    .PERIODO_PISCA (P)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .carga_if        (bus),
    .supressao_zeros (supressao_zeros),
    .pisca           (pisca),
    .saida           (saida),
    .anodo           (anodo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: everything derived from the edge count since reset release
  int          e;
  logic [15:0] m_ex;
  logic [15:0] m_sh;
  bit          m_pend;
  int          m_commit_at;
  logic [0:6]  exp_saida;
  logic [3:0]  exp_anodo;
  logic        exp_pronto;
  logic [0:6]  tabela [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    e          = 0;
    m_ex       = '0;
    m_sh       = '0;
    m_pend     = 0;
    exp_saida  = 7'h7F;
    exp_anodo  = 4'hF;
    exp_pronto = 1'b1;
  endtask

  // One clock: predict outputs from the pre-edge state, advance the model, compare
  task automatic ciclo();
    int         d;
    int         fs;
    bit         blank;
    logic [3:0] dig;
    @(posedge clk);
    d     = (e / DIV) % N;
    fs    = ((e / F) / P) % 2;
    dig   = m_ex[4*d +: 4];
    blank = (pisca[d] && fs == 1) || (supressao_zeros && d != 0 && (m_ex >> (4*d)) == 16'h0);
    exp_saida = blank ? 7'h7F : tabela[dig];
    exp_anodo = blank ? 4'hF : ~(4'b0001 << d);
    if (m_pend && e == m_commit_at) begin
      m_ex   = m_sh;
      m_pend = 0;
    end else if (bus.carga && !m_pend) begin
      m_sh        = bus.entrada;
      m_pend      = 1;
      m_commit_at = ((e + 1) / F) * F + F - 1;
    end
    exp_pronto = !m_pend;
    e++;
    #1;
    chk("saida", 32'(saida), 32'(exp_saida));
    chk("anodo", 32'(anodo), 32'(exp_anodo));
    chk("pronto", 32'(bus.pronto), 32'(exp_pronto));
  endtask

  task automatic carregar(input logic [15:0] v);
    bus.carga   = 1'b1;
    bus.entrada = v;
    ciclo();
    bus.carga   = 1'b0;
  endtask

  task automatic esperar_pronto(input string tag);
    int n = 0;
    while (!bus.pronto && n < 200) begin
      ciclo();
      n++;
    end
    chk(tag, 32'(bus.pronto), 32'd1);
  endtask

  logic [3:0] t1_an  [4];
  logic [0:6] t1_seg [4];

  initial begin
    tabela = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    t1_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    t1_seg = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};

    rst_n           = 1'b0;
    bus.carga       = 1'b0;
    bus.entrada     = '0;
    supressao_zeros = 1'b0;
    pisca           = '0;
    reset_model();
    #13;
    chk("reset_saida", 32'(saida), 32'h7F);
    chk("reset_anodo", 32'(anodo), 32'hF);
    chk("reset_pronto", 32'(bus.pronto), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ciclo();

    // Basic load, then walk one whole frame slot by slot
    carregar(16'h12AF);
    esperar_pronto("t1_pronto");
    while (e % F != 0) ciclo();
    for (int d = 0; d < N; d++) begin
      ciclo();
      chk("t1_anodo", 32'(anodo), 32'(t1_an[d]));
      chk("t1_saida", 32'(saida), 32'(t1_seg[d]));
      repeat (DIV - 1) ciclo();
    end

    // Second strobe while busy is dropped
    carregar(16'h0000);
    ciclo();
    carregar(16'h5555);
    esperar_pronto("t2_pronto");
    repeat (2 * F) ciclo();

    // Leading-zero suppression
    supressao_zeros = 1'b1;
    carregar(16'h0030);
    esperar_pronto("t3a_pronto");
    repeat (2 * F) ciclo();
    carregar(16'h0000);
    esperar_pronto("t3b_pronto");
    repeat (2 * F) ciclo();

    // Blink on digit 0
    supressao_zeros = 1'b0;
    carregar(16'h4321);
    esperar_pronto("t4_pronto");
    pisca = 4'b0001;
    repeat (6 * F) ciclo();
    pisca = '0;

    // Load accepted on the frame-boundary cycle lands one frame later
    while (e % F != F - 1) ciclo();
    carregar(16'hBEEF);
    repeat (F - 1) ciclo();
    chk("t5_still_busy", 32'(bus.pronto), 32'd0);
    ciclo();
    chk("t5_commit", 32'(bus.pronto), 32'd1);
    repeat (F) ciclo();

    // Reset mid-digit with a load pending
    carregar(16'h7777);
    repeat (3) ciclo();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_saida", 32'(saida), 32'h7F);
    chk("t6_anodo", 32'(anodo), 32'hF);
    chk("t6_pronto", 32'(bus.pronto), 32'd1);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * F) ciclo();

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      bus.carga   = ($urandom_range(0, 5) == 0);
      bus.entrada = 16'($urandom);
      if (k % 97 == 0) begin
        pisca           = 4'($urandom);
        supressao_zeros = 1'($urandom);
      end
      if (k % 5 == 0 && $urandom_range(0, 3) == 0) bus.entrada = 16'($urandom_range(0, 255));
      ciclo();
    end
    bus.carga = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
